// File: rtl/shift_pipe.sv
// ---------------------------------------------------------------------------
// shift_pipe
//
// Pipelined barrel shifter with valid/ready handshakes on both sides.
// It supports logical left, logical right, arithmetic right, rotate left and
// rotate right by a variable amount. The pipeline has AW = log2(WIDTH)
// stages, and stage k shifts by 2^k when bit k of the amount is set. The
// pipeline accepts one beat per cycle. Bubbles collapse, so an empty stage
// still fills while later stages are stalled.
//
// Optional feature macro: SHIFT_CARRY_EN
//    When it is defined, the out_carry port exists. out_carry carries the
//    last bit that was shifted or wrapped out, and it is pipelined alongside
//    out_data.
//
// Ports
//    clk        in   rising-edge clock
//    rst        in   synchronous active-high reset
//    in_valid   in   input beat valid
//    in_ready   out  the block can accept an input beat this cycle
//    in_data    in   operand (WIDTH bits)
//    in_amt     in   shift amount, 0 .. 2*WIDTH-1 (AW+1 bits)
//    in_mode    in   0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR, 5-7 pass-through
//    out_valid  out  result valid
//    out_ready  in   the consumer accepts the result
//    out_carry  out  last bit shifted or wrapped out (SHIFT_CARRY_EN only)
//    out_data   out  shifted result (WIDTH bits)
// ---------------------------------------------------------------------------
module shift_pipe #(
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AW:0]      in_amt,
   input  logic [2:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef SHIFT_CARRY_EN
   output logic             out_carry,
`endif
   output logic [WIDTH-1:0] out_data
);

   typedef enum logic [2:0] {
      MODE_LSL = 3'd0,
      MODE_LSR = 3'd1,
      MODE_ASR = 3'd2,
      MODE_ROL = 3'd3,
      MODE_ROR = 3'd4
   } shift_mode_t;

   localparam logic [WIDTH-1:0] LSB_ONE = WIDTH'(1);

   // Shift or rotate by s bits. Reserved modes pass the data through unchanged.
   function automatic logic [WIDTH-1:0] shift_data(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       mode,
                                                   input int               s);
      logic [WIDTH-1:0] r;
      r = d;
      case (mode)
         MODE_LSL: r = d << s;
         MODE_LSR: r = d >> s;
         MODE_ASR: r = $unsigned($signed(d) >>> s);
         MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
         MODE_ROR: r = (d >> s) | (d << (WIDTH - s));
         default:  r = d;
      endcase
      return r;
   endfunction

`ifdef SHIFT_CARRY_EN
   // Returns the last bit that leaves the word when shifting by s.
   // A rotate-left by s lands d[WIDTH-s] in bit 0, which is the same bit
   // that LSL shifts out last. Likewise ROR lands d[s-1] in the MSB.
   function automatic logic shift_carry(input logic [WIDTH-1:0] d,
                                        input logic [2:0]       mode,
                                        input int               s,
                                        input logic             c);
      case (mode)
         MODE_LSL, MODE_ROL:           return |(d & (LSB_ONE << (WIDTH - s)));
         MODE_LSR, MODE_ASR, MODE_ROR: return |(d & (LSB_ONE << (s - 1)));
         default:                      return c;
      endcase
   endfunction
`endif

   logic [WIDTH-1:0] entry_data;
   logic [AW-1:0]    entry_amt;

   // Resolve out-of-range amounts before the beat enters stage 0.
   // LSL and LSR become all zeros, and ASR becomes all copies of the sign.
   // Each of these then travels the pipeline with a zero amount. Rotates
   // simply drop the top amount bit, which gives the amount modulo WIDTH.
   // Reserved modes get a zero amount so that no stage touches them.
   always_comb begin
      entry_data = in_data;
      entry_amt  = in_amt[AW-1:0];
      if (in_amt[AW]) begin
         case (in_mode)
            MODE_LSL, MODE_LSR: begin
               entry_data = '0;
               entry_amt  = '0;
            end
            MODE_ASR: begin
               entry_data = {WIDTH{in_data[WIDTH-1]}};
               entry_amt  = '0;
            end
            default: ;
         endcase
      end
      if (in_mode > MODE_ROR) begin
         entry_amt = '0;
      end
   end

`ifdef SHIFT_CARRY_EN
   logic entry_carry;

   // An out-of-range ASR has already shifted the sign bit out. Every other
   // beat starts with a clear carry.
   always_comb begin
      entry_carry = 1'b0;
      if (in_amt[AW] && (in_mode == MODE_ASR)) begin
         entry_carry = in_data[WIDTH-1];
      end
   end
`endif

   for (genvar k = 0; k < AW; k++) begin : g_stage
      localparam int S = 1 << k;

      // Each stage sees only the amount bits that remain. Bit 0 is its own
      // bit, and the upper bits are handed on to later stages.
      logic             src_valid;
      logic [WIDTH-1:0] src_data;
      logic [2:0]       src_mode;
      logic [AW-k-1:0]  src_amt;
      logic [WIDTH-1:0] nxt_data;
      logic             st_valid;
      logic [WIDTH-1:0] st_data;
      logic             adv;

      if (k == 0) begin : g_src
         assign src_valid = in_valid;
         assign src_data  = entry_data;
         assign src_mode  = in_mode;
         assign src_amt   = entry_amt;
      end else begin : g_src
         assign src_valid = g_stage[k-1].st_valid;
         assign src_data  = g_stage[k-1].st_data;
         assign src_mode  = g_stage[k-1].g_ctl.st_mode;
         assign src_amt   = g_stage[k-1].g_ctl.st_amt;
      end

      // A stage may load when it is empty or when its contents move on.
      // The chain runs back from out_ready, so in_ready is combinational
      // from out_ready.
      if (k == AW - 1) begin : g_adv
         assign adv = !st_valid || out_ready;
      end else begin : g_adv
         assign adv = !st_valid || g_stage[k+1].adv;
      end

      assign nxt_data = src_amt[0] ? shift_data(src_data, src_mode, S) : src_data;

      // Valid and data register. Data only loads with a real beat, so the
      // output holds steady under backpressure and across bubbles.
      always_ff @(posedge clk) begin
         if (rst) begin
            st_valid <= 1'b0;
            st_data  <= '0;
         end else if (adv) begin
            st_valid <= src_valid;
            if (src_valid) begin
               st_data <= nxt_data;
            end
         end
      end

      // The mode and the remaining amount are only needed by later stages,
      // so the last stage does not carry them.
      if (k < AW - 1) begin : g_ctl
         logic [2:0]      st_mode;
         logic [AW-k-2:0] st_amt;

         always_ff @(posedge clk) begin
            if (rst) begin
               st_mode <= '0;
               st_amt  <= '0;
            end else if (adv && src_valid) begin
               st_mode <= src_mode;
               st_amt  <= src_amt[AW-k-1:1];
            end
         end
      end

`ifdef SHIFT_CARRY_EN
      logic src_carry;
      logic nxt_carry;
      logic st_carry;

      if (k == 0) begin : g_csrc
         assign src_carry = entry_carry;
      end else begin : g_csrc
         assign src_carry = g_stage[k-1].st_carry;
      end

      assign nxt_carry = src_amt[0] ? shift_carry(src_data, src_mode, S, src_carry)
                                    : src_carry;

      // The carry keeps the most recent bit that left the word. Stages that
      // do not shift leave it untouched.
      always_ff @(posedge clk) begin
         if (rst) begin
            st_carry <= 1'b0;
         end else if (adv && src_valid) begin
            st_carry <= nxt_carry;
         end
      end
`endif
   end

   assign in_ready  = g_stage[0].adv;
   assign out_valid = g_stage[AW-1].st_valid;
   assign out_data  = g_stage[AW-1].st_data;
`ifdef SHIFT_CARRY_EN
   assign out_carry = g_stage[AW-1].st_carry;
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_pipe
//
// Self-checking bench for shift_pipe at WIDTH = 8.
// Every accepted input beat pushes its expected result onto a scoreboard
// queue, and every output transfer pops the queue and compares. The first
// set of expected values comes from a table of hand-derived vectors. The
// later ones come from a reference model that shifts one bit at a time.
// The carry output is checked only when SHIFT_CARRY_EN is defined.
// ---------------------------------------------------------------------------
module tb_shift_pipe;

   localparam int W   = 8;
   localparam int LAT = 3;

   typedef struct {
      logic [7:0] data;
      logic [3:0] amt;
      logic [2:0] mode;
      logic [7:0] exp_data;
      logic       exp_carry;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       carry;
   } res_t;

   typedef struct {
      logic [7:0] data;
      logic       carry;
      int         acc_cyc;
      bit         chk_lat;
   } sb_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [3:0] in_amt;
   logic [2:0] in_mode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
`ifdef SHIFT_CARRY_EN
   logic       out_carry;
`endif

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   int   n_out = 0;
   sb_t  sb_q[$];
   vec_t vecs[18];

   shift_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef SHIFT_CARRY_EN
      .out_carry (out_carry),
`endif
      .out_data  (out_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // The reference model shifts one bit per step, the way the old 8-bit
   // unit worked. Explicit fix-ups cover the carry cases that the step
   // loop does not give on its own.
   function automatic res_t refModel(input logic [7:0] d, input logic [3:0] amt,
                                     input logic [2:0] mode);
      res_t e;
      logic [7:0] r;
      logic c;
      int n;
      r = d;
      c = 1'b0;
      n = int'(amt);
      for (int i = 0; i < n; i++) begin
         case (mode)
            3'd0: begin c = r[7]; r = {r[6:0], 1'b0}; end
            3'd1: begin c = r[0]; r = {1'b0, r[7:1]}; end
            3'd2: begin c = r[0]; r = {r[7], r[7:1]}; end
            3'd3: begin r = {r[6:0], r[7]}; c = r[0]; end
            3'd4: begin r = {r[0], r[7:1]}; c = r[7]; end
            default: ;
         endcase
      end
      if ((mode == 3'd0 || mode == 3'd1) && n >= W) c = 1'b0;
      if ((mode == 3'd3 || mode == 3'd4) && (n % W) == 0) c = 1'b0;
      e.data  = r;
      e.carry = c;
      return e;
   endfunction

   task automatic checkOutput();
      sb_t e;
      n_out++;
      tests++;
      if (sb_q.size() == 0) begin
         fails++;
         $display("[TB] FAIL unexpected_output: got %b, expected no output", out_data);
         return;
      end
      e = sb_q.pop_front();
      if (out_data !== e.data) begin
         fails++;
         $display("[TB] FAIL out_data: got %b, expected %b", out_data, e.data);
      end
`ifdef SHIFT_CARRY_EN
      tests++;
      if (out_carry !== e.carry) begin
         fails++;
         $display("[TB] FAIL out_carry: got %b, expected %b (data %b)", out_carry, e.carry, e.data);
      end
`endif
      if (e.chk_lat) begin
         tests++;
         if (cyc - e.acc_cyc != LAT) begin
            fails++;
            $display("[TB] FAIL latency: got %0d cycles, expected %0d", cyc - e.acc_cyc, LAT);
         end
      end
   endtask

   // Output transfers are sampled on the falling edge, away from the edge
   // that actually moves them.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) checkOutput();
   end

   // Offers one beat and holds it until it is accepted, within a bounded
   // number of cycles. The task returns one step after the rising edge that
   // took the beat, so consecutive calls drive back-to-back beats.
   task automatic applyStimulus(input logic [7:0] d, input logic [3:0] a, input logic [2:0] m,
                                input res_t exp_r, input bit chk_lat);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_mode  = m;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (in_ready && !rst) begin
            sb_q.push_back('{exp_r.data, exp_r.carry, cyc, chk_lat});
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      tests++;
      if (!done) begin
         fails++;
         $display("[TB] FAIL accept_timeout: got in_ready=0 for 20 cycles, expected acceptance");
      end
   endtask

   task automatic waitDrain(input int bound);
      for (int i = 0; i < bound && sb_q.size() != 0; i++) @(negedge clk);
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("[TB] FAIL drain: got %0d results pending, expected 0", sb_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkBit(input string name, input logic got, input logic expv);
      tests++;
      if (got !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %b, expected %b", name, got, expv);
      end
   endtask

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: got no finish, expected the run to end");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      res_t r;
      int idx;
      int n0;
      int sent;
      logic [7:0] stalled;

      vecs[0]  = '{8'hEB, 4'd1,  3'd0, 8'hD6, 1'b1};
      vecs[1]  = '{8'hEB, 4'd1,  3'd1, 8'h75, 1'b1};
      vecs[2]  = '{8'hEB, 4'd1,  3'd2, 8'hF5, 1'b1};
      vecs[3]  = '{8'hEB, 4'd1,  3'd3, 8'hD7, 1'b1};
      vecs[4]  = '{8'hEB, 4'd1,  3'd4, 8'hF5, 1'b1};
      vecs[5]  = '{8'hEB, 4'd9,  3'd0, 8'h00, 1'b0};
      vecs[6]  = '{8'hEB, 4'd9,  3'd2, 8'hFF, 1'b1};
      vecs[7]  = '{8'hEB, 4'd9,  3'd3, 8'hD7, 1'b1};
      vecs[8]  = '{8'hEB, 4'd0,  3'd4, 8'hEB, 1'b0};
      vecs[9]  = '{8'hEB, 4'd3,  3'd3, 8'h5F, 1'b1};
      vecs[10] = '{8'hEB, 4'd5,  3'd6, 8'hEB, 1'b0};
      vecs[11] = '{8'hEB, 4'd7,  3'd1, 8'h01, 1'b1};
      vecs[12] = '{8'hEB, 4'd15, 3'd2, 8'hFF, 1'b1};
      vecs[13] = '{8'hEB, 4'd8,  3'd4, 8'hEB, 1'b0};
      vecs[14] = '{8'hEB, 4'd8,  3'd0, 8'h00, 1'b0};
      vecs[15] = '{8'h6B, 4'd9,  3'd2, 8'h00, 1'b0};
      vecs[16] = '{8'hEB, 4'd7,  3'd0, 8'h80, 1'b1};
      vecs[17] = '{8'h6B, 4'd4,  3'd4, 8'hB6, 1'b1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      in_mode   = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      checkBit("reset_out_valid", out_valid, 1'b0);
      checkBit("reset_in_ready", in_ready, 1'b1);
      tests++;
      if (out_data !== 8'h00) begin
         fails++;
         $display("[TB] FAIL reset_out_data: got %b, expected 00000000", out_data);
      end
      @(posedge clk);
      #1;

      // Table vectors, back-to-back, with the consumer always ready
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         r.data  = vecs[i].exp_data;
         r.carry = vecs[i].exp_carry;
         applyStimulus(vecs[i].data, vecs[i].amt, vecs[i].mode, r, 1'b1);
      end
      in_valid = 1'b0;
      waitDrain(20);

      // Backpressure: offer 5 beats while the consumer is stalled
      out_ready = 1'b0;
      n0  = n_out;
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         in_data  = 8'h3C + 8'(idx * 17);
         in_amt   = 4'(idx + 1);
         in_mode  = 3'(idx);
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back('{refModel(in_data, in_amt, in_mode).data,
                             refModel(in_data, in_amt, in_mode).carry, cyc, 1'b0});
            idx++;
         end
         @(posedge clk);
         #1;
      end
      tests++;
      if (idx != 3) begin
         fails++;
         $display("[TB] FAIL bp_accept_count: got %0d, expected 3", idx);
      end
      @(negedge clk);
      checkBit("bp_in_ready_full", in_ready, 1'b0);
      checkBit("bp_out_valid_stalled", out_valid, 1'b1);
      stalled = out_data;
      repeat (2) @(negedge clk);
      tests++;
      if (out_data !== stalled) begin
         fails++;
         $display("[TB] FAIL bp_hold: got %b, expected %b", out_data, stalled);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && idx < 5; c++) begin
         in_valid = 1'b1;
         in_data  = 8'h3C + 8'(idx * 17);
         in_amt   = 4'(idx + 1);
         in_mode  = 3'(idx);
         @(negedge clk);
         if (in_ready) begin
            sb_q.push_back('{refModel(in_data, in_amt, in_mode).data,
                             refModel(in_data, in_amt, in_mode).carry, cyc, 1'b0});
            idx++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      waitDrain(20);
      tests++;
      if (n_out - n0 != 5) begin
         fails++;
         $display("[TB] FAIL bp_result_count: got %0d, expected 5", n_out - n0);
      end

      // Reset with 3 beats in flight
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(8'hA0 + 8'(i), 4'd2, 3'd3, refModel(8'hA0 + 8'(i), 4'd2, 3'd3), 1'b0);
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
      n0 = n_out;
      @(negedge clk);
      checkBit("rst_mid_out_valid", out_valid, 1'b0);
      checkBit("rst_mid_in_ready", in_ready, 1'b1);
      tests++;
      if (out_data !== 8'h00) begin
         fails++;
         $display("[TB] FAIL rst_mid_out_data: got %b, expected 00000000", out_data);
      end
`ifdef SHIFT_CARRY_EN
      checkBit("rst_mid_out_carry", out_carry, 1'b0);
`endif
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      tests++;
      if (n_out != n0) begin
         fails++;
         $display("[TB] FAIL rst_stale_output: got %0d results, expected 0", n_out - n0);
      end

      // Random stream with random handshake toggling
      sent = 0;
      for (int c = 0; c < 60000 && sent < 10000; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         in_amt    = 4'($urandom);
         in_mode   = 3'($urandom);
         @(negedge clk);
         if (in_valid && in_ready) begin
            r = refModel(in_data, in_amt, in_mode);
            sb_q.push_back('{r.data, r.carry, cyc, 1'b0});
            sent++;
         end
         @(posedge clk);
         #1;
      end
      tests++;
      if (sent != 10000) begin
         fails++;
         $display("[TB] FAIL random_accept: got %0d beats, expected 10000", sent);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waitDrain(40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
